// File: rtl/aftab_interrupt_cause_arbiter_if.sv
// aftab_interrupt_cause_arbiter_if: interrupt sources, exception and trap request bundle
interface aftab_interrupt_cause_arbiter_if #(
    parameter int LEN      = 32,
    parameter int NUM_PLAT = 8
) ();
    logic                ext_intr_i;
    logic                soft_intr_i;
    logic                timer_intr_i;
    logic [NUM_PLAT-1:0] plat_intr_i;
    logic [LEN-1:0]      mie_reg_i;
    logic                global_ie_i;
    logic                exception_valid_i;
    logic [3:0]          exception_code_i;
    logic                ack_i;
    logic                trap_req_o;
    logic [5:0]          cause_code_o;
    logic                interrupt_flag_o;
    logic [LEN-1:0]      pending_bits_o;

    modport slave (
        input  ext_intr_i, soft_intr_i, timer_intr_i, plat_intr_i, mie_reg_i, global_ie_i,
               exception_valid_i, exception_code_i, ack_i,
        output trap_req_o, cause_code_o, interrupt_flag_o, pending_bits_o
    );

    modport master (
        output ext_intr_i, soft_intr_i, timer_intr_i, plat_intr_i, mie_reg_i, global_ie_i,
               exception_valid_i, exception_code_i, ack_i,
        input  trap_req_o, cause_code_o, interrupt_flag_o, pending_bits_o
    );
endinterface

// File: rtl/aftab_interrupt_cause_arbiter.sv
// aftab_interrupt_cause_arbiter: synchronises interrupts and presents a frozen trap cause
module aftab_interrupt_cause_arbiter #(
    parameter int LEN      = 32,
    parameter int NUM_PLAT = 8
) (
    input logic                           clk,
    input logic                           rst_n,
    aftab_interrupt_cause_arbiter_if.slave bus_if
);
    localparam int NS = NUM_PLAT + 3;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t         state_q, state_d;
    logic [NS-1:0]  raw, sync1_q, sync2_q;
    logic [LEN-1:0] pend_q, pend_d, en;
    logic           trap_q, trap_d, flag_q, flag_d;
    logic [5:0]     cause_q, cause_d, irq_cause;

    assign raw = {bus_if.plat_intr_i, bus_if.timer_intr_i, bus_if.soft_intr_i, bus_if.ext_intr_i};
    assign en  = pend_q & bus_if.mie_reg_i;

    assign bus_if.trap_req_o       = trap_q;
    assign bus_if.cause_code_o     = cause_q;
    assign bus_if.interrupt_flag_o = flag_q;
    assign bus_if.pending_bits_o   = pend_q;

    // place synchronised sources at their mip bit positions
    always_comb begin
        pend_d     = '0;
        pend_d[11] = sync2_q[0];
        pend_d[3]  = sync2_q[1];
        pend_d[7]  = sync2_q[2];
        for (int i = 0; i < NUM_PLAT; i++) pend_d[16+i] = sync2_q[3+i];
    end

    // lowest priority assigned first so higher-priority causes overwrite it
    always_comb begin
        irq_cause = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) if (en[16+i]) irq_cause = 6'(16 + i);
        if (en[7]) irq_cause = 6'd7;
        if (en[3]) irq_cause = 6'd3;
        if (en[11]) irq_cause = 6'd11;
    end

    // trap FSM: cause is captured only on entry to REQ and frozen until ack
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        flag_d  = flag_q;
        case (state_q)
            IDLE: begin
                if (bus_if.exception_valid_i) begin
                    state_d = REQ;
                    cause_d = {2'b00, bus_if.exception_code_i};
                    flag_d  = 1'b0;
                end else if (bus_if.global_ie_i && |en) begin
                    state_d = REQ;
                    cause_d = irq_cause;
                    flag_d  = 1'b1;
                end
            end
            REQ:     state_d = bus_if.ack_i ? HOLD : REQ;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        trap_d = state_d == REQ;
    end

    // state, synchronisers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            pend_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= raw;
            sync2_q <= sync1_q;
            pend_q  <= pend_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_aftab_interrupt_cause_arbiter.sv
// tb_aftab_interrupt_cause_arbiter: directed stimulus with a cycle-level reference model
module tb_aftab_interrupt_cause_arbiter;
    localparam int LEN = 32;
    localparam int NP  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    aftab_interrupt_cause_arbiter_if #(.LEN(LEN), .NUM_PLAT(NP)) bus ();
    aftab_interrupt_cause_arbiter #(.LEN(LEN), .NUM_PLAT(NP)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // first enabled cause in priority order ext, soft, timer, plat[0..NP-1]
    function automatic int pick(input logic [31:0] e);
        int c;
        for (int k = 0; k < 3 + NP; k++) begin
            c = (k == 0) ? 11 : (k == 1) ? 3 : (k == 2) ? 7 : 13 + k;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] spread(input logic [NP+2:0] v);
        logic [31:0] r;
        r = '0;
        r[11] = v[0];
        r[3] = v[1];
        r[7] = v[2];
        for (int i = 0; i < NP; i++) r[16+i] = v[3+i];
        return r;
    endfunction

    logic        m_trap, m_flag;
    logic [5:0]  m_cause;
    logic [31:0] m_pend;
    logic [NP+2:0] dly0, dly1;
    int          m_mode;

    // reference model: 0 idle, 1 requesting, 2 one-cycle hold; pending is the source vector three edges late
    always @(posedge clk or negedge rst_n) begin
        int c, nm;
        if (!rst_n) begin
            m_mode <= 0;
            m_trap <= 1'b0;
            m_flag <= 1'b0;
            m_cause <= '0;
            m_pend <= '0;
            dly0 <= '0;
            dly1 <= '0;
        end else begin
            c = pick(m_pend & bus.mie_reg_i);
            nm = m_mode;
            if (m_mode == 0) begin
                if (bus.exception_valid_i) begin
                    nm = 1;
                    m_cause <= {2'b00, bus.exception_code_i};
                    m_flag <= 1'b0;
                end else if (bus.global_ie_i && c >= 0) begin
                    nm = 1;
                    m_cause <= 6'(c);
                    m_flag <= 1'b1;
                end
            end else if (m_mode == 1) begin
                if (bus.ack_i) nm = 2;
            end else nm = 0;
            m_mode <= nm;
            m_trap <= nm == 1;
            m_pend <= spread(dly1);
            dly1 <= dly0;
            dly0 <= {bus.plat_intr_i, bus.timer_intr_i, bus.soft_intr_i, bus.ext_intr_i};
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("trap_req", 32'(bus.trap_req_o), 32'(m_trap));
        check("cause_code", 32'(bus.cause_code_o), 32'(m_cause));
        check("interrupt_flag", 32'(bus.interrupt_flag_o), 32'(m_flag));
        check("pending_bits", bus.pending_bits_o, m_pend);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_trap(input int budget);
        int n = 0;
        while (!bus.trap_req_o && n < budget) begin
            tick();
            n++;
        end
        check("wait_trap", 32'(bus.trap_req_o), 32'd1);
    endtask

    task automatic sources(input logic v);
        bus.ext_intr_i = v;
        bus.soft_intr_i = v;
        bus.timer_intr_i = v;
        bus.plat_intr_i = {NP{v}};
    endtask

    task automatic drain();
        bus.global_ie_i = 1'b0;
        bus.exception_valid_i = 1'b0;
        sources(1'b0);
        if (bus.trap_req_o) begin
            bus.ack_i = 1'b1;
            tick();
            bus.ack_i = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic ack_pulse();
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
    endtask

    initial begin
        sources(1'b1);
        bus.mie_reg_i = '1;
        bus.global_ie_i = 1'b1;
        bus.exception_valid_i = 1'b0;
        bus.exception_code_i = '0;
        bus.ack_i = 1'b0;
        // T1 reset with all sources high
        repeat (2) tick();
        check("rst_trap", 32'(bus.trap_req_o), 32'd0);
        check("rst_cause", 32'(bus.cause_code_o), 32'd0);
        check("rst_flag", 32'(bus.interrupt_flag_o), 32'd0);
        check("rst_pend", bus.pending_bits_o, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("t1_no_trap_yet", 32'(bus.trap_req_o), 32'd0);
        tick();
        check("t1_trap", 32'(bus.trap_req_o), 32'd1);
        check("t1_cause", 32'(bus.cause_code_o), 32'd11);
        drain();
        // T2 single timer interrupt
        bus.mie_reg_i = 32'h80;
        bus.global_ie_i = 1'b1;
        bus.timer_intr_i = 1'b1;
        repeat (2) tick();
        check("t2_pend_early", bus.pending_bits_o, 32'd0);
        tick();
        check("t2_pend", bus.pending_bits_o, 32'h80);
        check("t2_trap_early", 32'(bus.trap_req_o), 32'd0);
        tick();
        check("t2_trap", 32'(bus.trap_req_o), 32'd1);
        check("t2_cause", 32'(bus.cause_code_o), 32'd7);
        check("t2_flag", 32'(bus.interrupt_flag_o), 32'd1);
        repeat (3) tick();
        check("t2_held", 32'(bus.trap_req_o), 32'd1);
        ack_pulse();
        check("t2_hold_low", 32'(bus.trap_req_o), 32'd0);
        repeat (2) tick();
        check("t2_retrap", 32'(bus.trap_req_o), 32'd1);
        drain();
        // T3 priority ladder
        bus.mie_reg_i = '1;
        bus.global_ie_i = 1'b1;
        bus.ext_intr_i = 1'b1;
        bus.soft_intr_i = 1'b1;
        bus.timer_intr_i = 1'b1;
        bus.plat_intr_i = 8'h04;
        wait_trap(8);
        check("t3_cause0", 32'(bus.cause_code_o), 32'd11);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) bus.ext_intr_i = 1'b0;
            else if (k == 1) bus.soft_intr_i = 1'b0;
            else bus.timer_intr_i = 1'b0;
            repeat (3) tick();
            ack_pulse();
            wait_trap(6);
            check("t3_cause", 32'(bus.cause_code_o), (k == 0) ? 32'd3 : (k == 1) ? 32'd7 : 32'd18);
        end
        drain();
        // T4 exception beats a simultaneous interrupt
        bus.mie_reg_i = '1;
        bus.global_ie_i = 1'b1;
        bus.ext_intr_i = 1'b1;
        repeat (3) tick();
        bus.exception_valid_i = 1'b1;
        bus.exception_code_i = 4'd2;
        tick();
        check("t4_trap", 32'(bus.trap_req_o), 32'd1);
        check("t4_cause", 32'(bus.cause_code_o), 32'd2);
        check("t4_flag", 32'(bus.interrupt_flag_o), 32'd0);
        bus.exception_valid_i = 1'b0;
        ack_pulse();
        wait_trap(6);
        check("t4_irq_cause", 32'(bus.cause_code_o), 32'd11);
        check("t4_irq_flag", 32'(bus.interrupt_flag_o), 32'd1);
        drain();
        // T5 global gating, then freeze against preemption
        bus.mie_reg_i = '1;
        sources(1'b1);
        repeat (8) tick();
        check("t5_gated", 32'(bus.trap_req_o), 32'd0);
        sources(1'b0);
        bus.timer_intr_i = 1'b1;
        bus.mie_reg_i = 32'h880;
        repeat (4) tick();
        bus.global_ie_i = 1'b1;
        wait_trap(6);
        check("t5_cause", 32'(bus.cause_code_o), 32'd7);
        bus.ext_intr_i = 1'b1;
        bus.timer_intr_i = 1'b0;
        repeat (5) tick();
        check("t5_frozen_trap", 32'(bus.trap_req_o), 32'd1);
        check("t5_frozen_cause", 32'(bus.cause_code_o), 32'd7);
        ack_pulse();
        wait_trap(6);
        check("t5_next_cause", 32'(bus.cause_code_o), 32'd11);
        // T6 asynchronous reset while requesting
        rst_n = 1'b0;
        #1;
        check("t6_trap", 32'(bus.trap_req_o), 32'd0);
        check("t6_cause", 32'(bus.cause_code_o), 32'd0);
        check("t6_pend", bus.pending_bits_o, 32'd0);
        sources(1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6_idle", 32'(bus.trap_req_o), 32'd0);
        bus.exception_valid_i = 1'b1;
        bus.exception_code_i = 4'd5;
        tick();
        check("t6_exc_trap", 32'(bus.trap_req_o), 32'd1);
        check("t6_exc_cause", 32'(bus.cause_code_o), 32'd5);
        bus.exception_valid_i = 1'b0;
        ack_pulse();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
